// File: rtl/fft2d_io_pkg.sv
// rtl/fft2d_io_pkg.sv - shared mode encoding, state enumeration and err bit indices
package fft2d_io_pkg;

    localparam logic [1:0] MODE_BYPASS  = 2'b00;
    localparam logic [1:0] MODE_SCATTER = 2'b01;
    localparam logic [1:0] MODE_GATHER  = 2'b10;
    localparam logic [1:0] MODE_IDLE    = 2'b11;

    // State codes equal the mode codes so cur_mode is the state register itself.
    typedef enum logic [1:0] {
        ST_BYPASS  = MODE_BYPASS,
        ST_SCATTER = MODE_SCATTER,
        ST_GATHER  = MODE_GATHER,
        ST_IDLE    = MODE_IDLE
    } state_t;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;

    function automatic state_t mode_to_state(input logic [1:0] m);
        state_t s;
        case (m)
            MODE_BYPASS:  s = ST_BYPASS;
            MODE_SCATTER: s = ST_SCATTER;
            MODE_GATHER:  s = ST_GATHER;
            default:      s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fft_sfifo_fwft.sv
// rtl/fft_sfifo_fwft.sv - single-clock first-word-fall-through FIFO
module fft_sfifo_fwft #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // An empty FIFO shows zero so stale storage never leaks onto the buses.
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fft2d_io_mux.sv
// rtl/fft2d_io_mux.sv - mode FSM, round-robin lane muxing and FIFO between external port and units
module fft2d_io_mux
    import fft2d_io_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int NUM_CH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic [DATA_W-1:0]          ext_din,
    input  logic                       ext_wr_en,
    output logic [DATA_W-1:0]          ext_dout,
    input  logic                       ext_rd_en,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [NUM_CH*DATA_W-1:0]   unit_dout,
    output logic [NUM_CH-1:0]          unit_dout_valid,
    input  logic [NUM_CH-1:0]          unit_dout_ready,
    input  logic [NUM_CH*DATA_W-1:0]   unit_din,
    input  logic [NUM_CH-1:0]          unit_din_valid,
    output logic [NUM_CH-1:0]          unit_din_ready,
    output logic [$clog2(NUM_CH)-1:0]  ch_ptr,
    output logic [1:0]                 cur_mode,
    output logic [1:0]                 err
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    state_t            state_q, state_d;
    state_t            req_state;
    logic [CH_W-1:0]   ch_ptr_q, ch_ptr_d;
    logic [1:0]        err_q, err_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_din;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;

    logic [DATA_W-1:0] lane_din;
    logic              lane_xfer;
    logic              ovf_hit;
    logic              unf_hit;

    assign req_state = mode_to_state(mode);
    assign cur_mode  = state_q;
    assign ch_ptr    = ch_ptr_q;
    assign err       = err_q;
    assign full      = fifo_full;
    assign empty     = fifo_empty;
    assign level     = fifo_level;

    fft_sfifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Lane muxes/demuxes and FIFO strobes; everything is held at zero during reset.
    always_comb begin
        unit_dout       = '0;
        unit_dout_valid = '0;
        unit_din_ready  = '0;
        ext_dout        = '0;
        fifo_push       = 1'b0;
        fifo_pop        = 1'b0;
        fifo_din        = '0;
        lane_xfer       = 1'b0;
        ovf_hit         = 1'b0;
        unf_hit         = 1'b0;
        lane_din        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == ch_ptr_q) lane_din = unit_din[k*DATA_W +: DATA_W];
        end
        if (!reset) begin
            case (state_q)
                ST_BYPASS: begin
                    unit_dout       = {NUM_CH{ext_din}};
                    unit_dout_valid = {NUM_CH{ext_wr_en}};
                    ext_dout        = unit_din[DATA_W-1:0];
                    unit_din_ready  = '1;
                end
                ST_SCATTER: begin
                    fifo_push = ext_wr_en & ~fifo_full;
                    fifo_din  = ext_din;
                    ovf_hit   = ext_wr_en & fifo_full;
                    lane_xfer = ~fifo_empty & unit_dout_ready[ch_ptr_q];
                    fifo_pop  = lane_xfer;
                    unit_dout_valid[ch_ptr_q] = ~fifo_empty;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (CH_W'(k) == ch_ptr_q) unit_dout[k*DATA_W +: DATA_W] = fifo_head;
                    end
                end
                ST_GATHER: begin
                    unit_din_ready[ch_ptr_q] = ~fifo_full;
                    lane_xfer = ~fifo_full & unit_din_valid[ch_ptr_q];
                    fifo_push = lane_xfer;
                    fifo_din  = lane_din;
                    ext_dout  = fifo_head;
                    fifo_pop  = ext_rd_en & ~fifo_empty;
                    unf_hit   = ext_rd_en & fifo_empty;
                end
                default: begin
                end
            endcase
        end
    end

    // Mode FSM next state: streaming modes only leave once drained and quiet.
    always_comb begin
        state_d  = state_q;
        ch_ptr_d = ch_ptr_q;
        err_d    = err_q;
        err_d[ERR_OVF] = err_q[ERR_OVF] | ovf_hit;
        err_d[ERR_UNF] = err_q[ERR_UNF] | unf_hit;
        if (lane_xfer) ch_ptr_d = ch_ptr_q + CH_W'(1);
        case (state_q)
            ST_IDLE, ST_BYPASS: state_d = req_state;
            ST_SCATTER, ST_GATHER: begin
                if ((req_state != state_q) && fifo_empty && !fifo_push && !fifo_pop)
                    state_d = req_state;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) ch_ptr_d = '0;
    end

    // State, lane pointer and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ch_ptr_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            ch_ptr_q <= ch_ptr_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_fft2d_io_mux.sv
// tb/tb_fft2d_io_mux.sv - self-checking bench for fft2d_io_mux
module tb_fft2d_io_mux;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int LVL_W  = 5;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [1:0]               mode;
    logic [DATA_W-1:0]        ext_din;
    logic                     ext_wr_en;
    logic [DATA_W-1:0]        ext_dout;
    logic                     ext_rd_en;
    logic                     full;
    logic                     empty;
    logic [LVL_W-1:0]         level;
    logic [NUM_CH*DATA_W-1:0] unit_dout;
    logic [NUM_CH-1:0]        unit_dout_valid;
    logic [NUM_CH-1:0]        unit_dout_ready;
    logic [NUM_CH*DATA_W-1:0] unit_din;
    logic [NUM_CH-1:0]        unit_din_valid;
    logic [NUM_CH-1:0]        unit_din_ready;
    logic [CH_W-1:0]          ch_ptr;
    logic [1:0]               cur_mode;
    logic [1:0]               err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [DATA_W-1:0]        din;
        logic                     wr;
        logic [DATA_W-1:0]        lane0;
        logic [NUM_CH*DATA_W-1:0] exp_udout;
        logic [NUM_CH-1:0]        exp_udv;
        logic [DATA_W-1:0]        exp_dout;
    } byp_vec_t;

    byp_vec_t byp_tab [4];

    // Reference model state: mode code, lane pointer, FIFO contents, error flags.
    int                m_state;
    int                m_ptr;
    logic [DATA_W-1:0] m_q [$];
    logic [1:0]        m_err;
    int                sz;
    int                nxt;
    logic              m_push;
    logic              m_pop;
    logic [DATA_W-1:0] pdat;
    logic [NUM_CH*DATA_W-1:0] e_udout;
    logic [NUM_CH-1:0] e_udv;
    logic [NUM_CH-1:0] e_udr;
    logic [DATA_W-1:0] e_dout;
    int                pct_hi;
    int                pct_lo;

    always #5 clk = ~clk;

    fft2d_io_mux #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mode            (mode),
        .ext_din         (ext_din),
        .ext_wr_en       (ext_wr_en),
        .ext_dout        (ext_dout),
        .ext_rd_en       (ext_rd_en),
        .full            (full),
        .empty           (empty),
        .level           (level),
        .unit_dout       (unit_dout),
        .unit_dout_valid (unit_dout_valid),
        .unit_dout_ready (unit_dout_ready),
        .unit_din        (unit_din),
        .unit_din_valid  (unit_din_valid),
        .unit_din_ready  (unit_din_ready),
        .ch_ptr          (ch_ptr),
        .cur_mode        (cur_mode),
        .err             (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        mode            = 2'b11;
        ext_din         = '0;
        ext_wr_en       = 1'b0;
        ext_rd_en       = 1'b0;
        unit_dout_ready = '0;
        unit_din        = '0;
        unit_din_valid  = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        byp_tab[0] = '{16'h1234, 1'b1, 16'hBEEF, 64'h1234_1234_1234_1234, 4'hF, 16'hBEEF};
        byp_tab[1] = '{16'hA5A5, 1'b0, 16'h0001, 64'hA5A5_A5A5_A5A5_A5A5, 4'h0, 16'h0001};
        byp_tab[2] = '{16'hFFFF, 1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 16'h0000};
        byp_tab[3] = '{16'h0000, 1'b1, 16'h8001, 64'h0000_0000_0000_0000, 4'hF, 16'h8001};

        // Reset state
        do_reset();
        #1;
        check("rst_mode", cur_mode, 2'b11);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_ch_ptr", ch_ptr, 0);
        check("rst_udout", unit_dout, 0);
        check("rst_udv", unit_dout_valid, 0);
        check("rst_udr", unit_din_ready, 0);
        check("rst_dout", ext_dout, 0);

        // BYPASS vectors
        mode = 2'b00;
        step();
        check("byp_mode", cur_mode, 2'b00);
        for (int i = 0; i < 4; i++) begin
            ext_din   = byp_tab[i].din;
            ext_wr_en = byp_tab[i].wr;
            unit_din  = {16'h7777, 16'h6666, 16'h5555, byp_tab[i].lane0};
            #1;
            check("byp_udout", unit_dout, byp_tab[i].exp_udout);
            check("byp_udv", unit_dout_valid, byp_tab[i].exp_udv);
            check("byp_dout", ext_dout, byp_tab[i].exp_dout);
            check("byp_udr", unit_din_ready, 4'hF);
            step();
            check("byp_level", level, 0);
        end

        // SCATTER round-robin
        do_reset();
        mode = 2'b01;
        step();
        check("sc_mode", cur_mode, 2'b01);
        ext_wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ext_din = 16'(i + 1);
            step();
        end
        ext_wr_en = 1'b0;
        #1;
        check("sc_level8", level, 8);
        unit_dout_ready = '1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("sc_valid", unit_dout_valid, 64'(1) << (i % 4));
            check("sc_lane", unit_dout[(i%4)*DATA_W +: DATA_W], i + 1);
            step();
        end
        #1;
        check("sc_empty", empty, 1);
        check("sc_ch_ptr", ch_ptr, 0);

        // Full and overflow
        do_reset();
        mode = 2'b01;
        step();
        ext_wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ext_din = 16'(16'h0100 + i);
            step();
            if (i == 15) begin
                check("ov_full16", full, 1);
                check("ov_level16", level, 16);
                check("ov_err_pre", err, 2'b00);
            end
        end
        ext_wr_en = 1'b0;
        #1;
        check("ov_err", err, 2'b01);
        check("ov_level", level, 16);
        unit_dout_ready = '1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("ov_read", unit_dout[(i%4)*DATA_W +: DATA_W], 16'h0100 + i);
            step();
        end
        #1;
        check("ov_empty", empty, 1);

        // Mode change blocked until drained
        do_reset();
        mode = 2'b01;
        step();
        ext_wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ext_din = 16'(16'h0031 + i);
            step();
        end
        ext_wr_en = 1'b0;
        mode = 2'b10;
        step();
        step();
        check("mc_hold", cur_mode, 2'b01);
        check("mc_level3", level, 3);
        unit_dout_ready = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mc_hold_pop", cur_mode, 2'b01);
        end
        check("mc_empty", empty, 1);
        unit_dout_ready = '0;
        step();
        check("mc_switch", cur_mode, 2'b10);
        check("mc_ch_ptr", ch_ptr, 0);

        // GATHER with a lane stall
        unit_din       = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        unit_din_valid = 4'b1011;
        #1;
        check("ga_udr0", unit_din_ready, 4'b0001);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ga_stall_ptr", ch_ptr, 2);
            check("ga_stall_udr", unit_din_ready, 4'b0100);
            step();
        end
        check("ga_level2", level, 2);
        unit_din_valid = '1;
        step();
        step();
        unit_din_valid = '0;
        #1;
        check("ga_ptr_wrap", ch_ptr, 0);
        check("ga_level4", level, 4);
        ext_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ga_dout", ext_dout, 16'h00A0 + i);
            step();
        end
        ext_rd_en = 1'b0;
        #1;
        check("ga_empty", empty, 1);
        check("ga_err_none", err, 2'b00);
        ext_rd_en = 1'b1;
        step();
        ext_rd_en = 1'b0;
        check("ga_underflow", err, 2'b10);
        check("ga_unf_level", level, 0);

        // Reset mid-operation
        unit_din_valid = '1;
        for (int i = 0; i < 5; i++) step();
        unit_din_valid = '0;
        #1;
        check("rm_level5", level, 5);
        reset = 1'b1;
        step();
        check("rm_level", level, 0);
        check("rm_empty", empty, 1);
        check("rm_full", full, 0);
        check("rm_mode", cur_mode, 2'b11);
        check("rm_err", err, 2'b00);
        check("rm_udr", unit_din_ready, 0);
        reset = 1'b0;

        // Randomised run against a queue-based model
        do_reset();
        m_state = 3;
        m_ptr   = 0;
        m_q.delete();
        m_err   = 2'b00;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            pct_hi = ((cyc / 80) % 2 == 0) ? 80 : 25;
            pct_lo = 105 - pct_hi;
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
            ext_din        = 16'($urandom);
            ext_wr_en      = ($urandom_range(0, 99) < pct_hi);
            ext_rd_en      = ($urandom_range(0, 99) < pct_lo);
            unit_din       = {$urandom(), $urandom()};
            for (int k = 0; k < NUM_CH; k++) begin
                unit_dout_ready[k] = ($urandom_range(0, 99) < pct_lo);
                unit_din_valid[k]  = ($urandom_range(0, 99) < pct_hi);
            end
            #1;
            sz      = m_q.size();
            e_udout = '0;
            e_udv   = '0;
            e_udr   = '0;
            e_dout  = '0;
            case (m_state)
                0: begin
                    for (int k = 0; k < NUM_CH; k++) e_udout[k*DATA_W +: DATA_W] = ext_din;
                    e_udv  = {NUM_CH{ext_wr_en}};
                    e_dout = unit_din[DATA_W-1:0];
                    e_udr  = '1;
                end
                1: begin
                    if (sz > 0) begin
                        e_udout[m_ptr*DATA_W +: DATA_W] = m_q[0];
                        e_udv[m_ptr] = 1'b1;
                    end
                end
                2: begin
                    e_udr[m_ptr] = (sz < DEPTH);
                    if (sz > 0) e_dout = m_q[0];
                end
                default: begin
                end
            endcase
            check("rnd_mode", cur_mode, m_state);
            check("rnd_ch_ptr", ch_ptr, m_ptr);
            check("rnd_level", level, sz);
            check("rnd_full", full, sz == DEPTH);
            check("rnd_empty", empty, sz == 0);
            check("rnd_err", err, m_err);
            check("rnd_dout", ext_dout, e_dout);
            check("rnd_udout", unit_dout, e_udout);
            check("rnd_udv", unit_dout_valid, e_udv);
            check("rnd_udr", unit_din_ready, e_udr);

            m_push = 1'b0;
            m_pop  = 1'b0;
            pdat   = '0;
            if (m_state == 1) begin
                pdat = ext_din;
                if (ext_wr_en) begin
                    if (sz < DEPTH) m_push = 1'b1;
                    else            m_err[0] = 1'b1;
                end
                if (sz > 0 && unit_dout_ready[m_ptr]) begin
                    m_pop = 1'b1;
                    m_ptr = (m_ptr + 1) % NUM_CH;
                end
            end else if (m_state == 2) begin
                if (unit_din_valid[m_ptr] && sz < DEPTH) begin
                    m_push = 1'b1;
                    pdat   = unit_din[m_ptr*DATA_W +: DATA_W];
                    m_ptr  = (m_ptr + 1) % NUM_CH;
                end
                if (ext_rd_en) begin
                    if (sz > 0) m_pop = 1'b1;
                    else        m_err[1] = 1'b1;
                end
            end
            if (m_pop)  void'(m_q.pop_front());
            if (m_push) m_q.push_back(pdat);
            nxt = m_state;
            if (m_state == 0 || m_state == 3) nxt = int'(mode);
            else if (int'(mode) != m_state && sz == 0 && !m_push && !m_pop) nxt = int'(mode);
            if (nxt != m_state) begin
                m_state = nxt;
                m_ptr   = 0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
